sonar_array: RTL and testbench

//  Parametrised successor to sensor_core: sequences NCH ultrasonic trig/echo channels in

---
 rtl/sonar_array.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_sonar_array.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_array.sv
// sonar_array: sequences NCH ultrasonic trig/echo channels in ascending round-robin
// sweeps and measures each echo width in pluse_us ticks. Control, status, results and
// error codes are accessed over fx_bus; fx_q is ORed onto the shared read bus.
// Ports:
//   clk_sys, rst_n (synchronous, active low), pluse_us (1-cycle microsecond tick)
//   dev_id        fx_bus device id compared with addr[21:16]
//   fire_measure  1-cycle start pulse
//   trig / echo   per-channel trigger outputs / asynchronous echo inputs
//   busy          high whenever the sequencer is not idle
//   done_measure  1-cycle pulse at the end of every completed sweep
//   fx_waddr/fx_wr/fx_data, fx_raddr/fx_rd, fx_q   fx_bus write, read and read data
// Timing counters advance only on pluse_us.
module sonar_array #(
  parameter int NCH      = 4,
  parameter int CW       = 16,
  parameter int TRIG_US  = 10,
  parameter int TMO_US   = 25000,
  parameter int GUARD_US = 10000
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            pluse_us,
  input  logic [5:0]      dev_id,
  input  logic            fire_measure,
  output logic [NCH-1:0]  trig,
  input  logic [NCH-1:0]  echo,
  output logic            busy,
  output logic            done_measure,
  input  logic [21:0]     fx_waddr,
  input  logic            fx_wr,
  input  logic [7:0]      fx_data,
  input  logic [21:0]     fx_raddr,
  input  logic            fx_rd,
  output logic [7:0]      fx_q
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_R, S_MEAS, S_GUARD} state_t;

  state_t            state_q, state_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic [NCH-1:0]    mask_q, mask_d;
  logic              armed_q, armed_d;
  logic [31:0]       tmr_q, tmr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     result_q [NCH];
  logic [CW-1:0]     result_d [NCH];
  logic [1:0]        err_q [NCH];
  logic [1:0]        err_d [NCH];
  logic [NCH-1:0]    ch_en_q, ch_en_d;
  logic              cont_q, cont_d;
  logic              sweep_done_q, sweep_done_d;
  logic [NCH-1:0]    echo_meta_q, echo_meta_d;
  logic [NCH-1:0]    echo_sync_q, echo_sync_d;
  logic [NCH-1:0]    trig_q, trig_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        rdata_q, rdata_d;

  logic              wr_hit_s, rd_hit_s, ctrl_wr_s, start_req_s, abort_req_s, status_rd_s;
  logic [15:0]       woff_s, roff_s;
  logic [CHW:0]      pick_first_s, pick_next_s;
  logic [31:0]       tmr_inc_s;
  logic [CW-1:0]     cnt_inc_s;
  logic              sweep_end_s;
  logic [15:0]       res16_s [NCH];
  logic              unused_data_s;

  // Lowest set bit of m (above cur when 'after' is set); MSB of the result is 'found'.
  function automatic logic [CHW:0] pick_ch(input logic [NCH-1:0] m, input logic [CHW-1:0] cur,
                                          input logic after);
    logic [CHW:0] r;
    r = {(CHW+1){1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (!after || (i > int'(cur)))) r = {1'b1, CHW'(i)};
    end
    return r;
  endfunction

  assign unused_data_s = ^fx_data;
  assign trig          = trig_q;
  assign busy          = busy_q;
  assign done_measure  = done_q;
  assign fx_q          = rdata_q;

  // fx_bus address decode and command strobes
  always_comb begin
    woff_s      = fx_waddr[15:0];
    roff_s      = fx_raddr[15:0];
    wr_hit_s    = fx_wr && (fx_waddr[21:16] == dev_id);
    rd_hit_s    = fx_rd && (fx_raddr[21:16] == dev_id);
    ctrl_wr_s   = wr_hit_s && (woff_s == 16'h0000);
    start_req_s = fire_measure || (ctrl_wr_s && fx_data[0]);
    abort_req_s = ctrl_wr_s && fx_data[2];
    status_rd_s = rd_hit_s && (roff_s == 16'h0002);
    tmr_inc_s   = tmr_q + 32'd1;
    cnt_inc_s   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};
    pick_first_s = pick_ch(ch_en_q, {CHW{1'b0}}, 1'b0);
    pick_next_s  = pick_ch(mask_q, ch_q, 1'b1);
  end

  // Echo synchroniser inputs
  always_comb begin
    echo_meta_d = echo;
    echo_sync_d = echo_meta_q;
  end

  // Next-state logic and per-channel measurement datapath
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    mask_d      = mask_q;
    armed_d     = armed_q;
    tmr_d       = tmr_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    err_d       = err_q;
    sweep_end_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_req_s && pick_first_s[CHW]) begin
          state_d = S_TRIG;
          mask_d  = ch_en_q;
          ch_d    = pick_first_s[CHW-1:0];
          armed_d = 1'b0;
          tmr_d   = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG: begin
        // First TRIG cycle only checks for an echo that is already high.
        if (!armed_q) begin
          if (echo_sync_q[ch_q]) begin
            err_d[ch_q] = 2'b11;
            state_d     = S_GUARD;
            tmr_d       = 32'd0;
          end else begin
            armed_d = 1'b1;
          end
        end else if (pluse_us) begin
          if (tmr_inc_s == 32'(TRIG_US)) begin
            state_d = S_WAIT_R;
            tmr_d   = 32'd0;
          end else begin
            tmr_d = tmr_inc_s;
          end
        end else begin
          tmr_d = tmr_q;
        end
      end
      S_WAIT_R: begin
        if (echo_sync_q[ch_q]) begin
          state_d = S_MEAS;
          cnt_d   = {CW{1'b0}};
        end else if (pluse_us) begin
          if (tmr_inc_s == 32'(TMO_US)) begin
            err_d[ch_q] = 2'b01;
            state_d     = S_GUARD;
            tmr_d       = 32'd0;
          end else begin
            tmr_d = tmr_inc_s;
          end
        end else begin
          tmr_d = tmr_q;
        end
      end
      S_MEAS: begin
        if (!echo_sync_q[ch_q]) begin
          result_d[ch_q] = cnt_q;
          err_d[ch_q]    = 2'b00;
          state_d        = S_GUARD;
          tmr_d          = 32'd0;
        end else if (pluse_us) begin
          if (32'(cnt_inc_s) == 32'(TMO_US)) begin
            result_d[ch_q] = {CW{1'b1}};
            err_d[ch_q]    = 2'b10;
            state_d        = S_GUARD;
            tmr_d          = 32'd0;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_GUARD: begin
        if (pluse_us && (tmr_inc_s == 32'(GUARD_US))) begin
          tmr_d   = 32'd0;
          armed_d = 1'b0;
          if (pick_next_s[CHW]) begin
            state_d = S_TRIG;
            ch_d    = pick_next_s[CHW-1:0];
          end else begin
            sweep_end_s = 1'b1;
            // Continuous mode re-latches CH_EN so edits apply from this new sweep.
            if (cont_q && pick_first_s[CHW]) begin
              state_d = S_TRIG;
              mask_d  = ch_en_q;
              ch_d    = pick_first_s[CHW-1:0];
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (pluse_us) begin
          tmr_d = tmr_inc_s;
        end else begin
          tmr_d = tmr_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort discards whatever the in-flight channel would have written.
    if (abort_req_s) begin
      state_d     = S_IDLE;
      result_d    = result_q;
      err_d       = err_q;
      sweep_end_s = 1'b0;
    end else begin
      sweep_end_s = sweep_end_s;
    end
  end

  // Registered outputs derived from the next state
  always_comb begin
    trig_d = {NCH{1'b0}};
    if ((state_d == S_TRIG) && armed_d) begin
      trig_d[ch_d] = 1'b1;
    end else begin
      trig_d = {NCH{1'b0}};
    end
    busy_d = (state_d != S_IDLE);
    done_d = sweep_end_s;
  end

  // Control/status register updates
  always_comb begin
    ch_en_d = ch_en_q;
    cont_d  = cont_q;
    if (wr_hit_s && (woff_s == 16'h0001)) begin
      ch_en_d = fx_data[NCH-1:0];
    end else begin
      ch_en_d = ch_en_q;
    end
    if (ctrl_wr_s) begin
      cont_d = fx_data[1];
    end else begin
      cont_d = cont_q;
    end
    // A set in the same cycle as a STATUS read wins, so the flag is never lost.
    if (sweep_end_s) begin
      sweep_done_d = 1'b1;
    end else if (status_rd_s) begin
      sweep_done_d = 1'b0;
    end else begin
      sweep_done_d = sweep_done_q;
    end
  end

  // Results zero-extended to the 16-bit register view
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      res16_s[i] = 16'(result_q[i]);
    end
  end

  // Read data mux; fx_q holds until the next fx_rd
  always_comb begin
    rdata_d = rdata_q;
    if (fx_rd) begin
      rdata_d = 8'h00;
      if (rd_hit_s) begin
        case (roff_s)
          16'h0000: rdata_d = {6'b000000, cont_q, 1'b0};
          16'h0001: rdata_d = 8'(ch_en_q);
          16'h0002: rdata_d = {6'b000000, sweep_done_q | sweep_end_s, busy_q};
          default:  rdata_d = 8'h00;
        endcase
        for (int i = 0; i < NCH; i++) begin
          if (roff_s == 16'(32'h10 + 2 * i)) begin
            rdata_d = res16_s[i][7:0];
          end else if (roff_s == 16'(32'h11 + 2 * i)) begin
            rdata_d = res16_s[i][15:8];
          end else if (roff_s == 16'(32'h30 + i)) begin
            rdata_d = {6'b000000, err_q[i]};
          end else begin
            rdata_d = rdata_d;
          end
        end
      end else begin
        rdata_d = 8'h00;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State and register flops with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ch_q         <= {CHW{1'b0}};
      mask_q       <= {NCH{1'b0}};
      armed_q      <= 1'b0;
      tmr_q        <= 32'd0;
      cnt_q        <= {CW{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        result_q[i] <= {CW{1'b0}};
        err_q[i]    <= 2'b00;
      end
      ch_en_q      <= {NCH{1'b1}};
      cont_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      echo_meta_q  <= {NCH{1'b0}};
      echo_sync_q  <= {NCH{1'b0}};
      trig_q       <= {NCH{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      mask_q       <= mask_d;
      armed_q      <= armed_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      err_q        <= err_d;
      ch_en_q      <= ch_en_d;
      cont_q       <= cont_d;
      sweep_done_q <= sweep_done_d;
      echo_meta_q  <= echo_meta_d;
      echo_sync_q  <= echo_sync_d;
      trig_q       <= trig_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sonar_array.sv
// Directed/randomised bench for sonar_array with shortened timing parameters.
module tb_sonar_array;
  localparam int NCH = 4;
  localparam int CW = 16;
  localparam int TRIG_US = 10;
  localparam int TMO_US = 200;
  localparam int GUARD_US = 50;
  localparam logic [5:0] DEV = 6'h2A;
  localparam int BOUND = 4 * (TRIG_US + TMO_US + GUARD_US + 60);
  localparam int K_ECHO = 0;
  localparam int K_NORISE = 1;

  logic clk_sys, rst_n, pluse_us, fire_measure, busy, done_measure, fx_wr, fx_rd;
  logic [NCH-1:0] trig, echo;
  logic [21:0] fx_waddr, fx_raddr;
  logic [7:0] fx_data, fx_q;

  int checks = 0;
  int errors = 0;
  int trig_rises[NCH];
  int trig_ticks[NCH];
  int done_cnt = 0;
  logic [NCH-1:0] trig_prev = '0;
  int exp_res[NCH];
  int exp_err[NCH];
  int tick_ph = 0;

  sonar_array #(.NCH(NCH), .CW(CW), .TRIG_US(TRIG_US), .TMO_US(TMO_US), .GUARD_US(GUARD_US)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .pluse_us(pluse_us), .dev_id(DEV),
    .fire_measure(fire_measure), .trig(trig), .echo(echo), .busy(busy),
    .done_measure(done_measure), .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q));

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Microsecond tick: one cycle in four, changed just after the rising edge.
  initial begin
    pluse_us = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      pluse_us = (tick_ph == 3);
      tick_ph = (tick_ph + 1) % 4;
    end
  end

  // Observer: trig rises, ticks spent with trig high, done pulses.
  initial begin
    for (int c = 0; c < NCH; c++) begin
      trig_rises[c] = 0;
      trig_ticks[c] = 0;
    end
    forever begin
      @(negedge clk_sys);
      for (int c = 0; c < NCH; c++) begin
        if (trig[c] && !trig_prev[c]) trig_rises[c]++;
        if (trig[c] && pluse_us) trig_ticks[c]++;
      end
      trig_prev = trig;
      if (done_measure) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic bus_wr(input logic [15:0] off, input logic [7:0] d);
    @(negedge clk_sys);
    fx_waddr = {DEV, off};
    fx_data = d;
    fx_wr = 1'b1;
    @(negedge clk_sys);
    fx_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [5:0] dev, input logic [15:0] off, output logic [7:0] d);
    @(negedge clk_sys);
    fx_raddr = {dev, off};
    fx_rd = 1'b1;
    @(negedge clk_sys);
    fx_rd = 1'b0;
    d = fx_q;
  endtask

  task automatic fire();
    @(negedge clk_sys);
    fire_measure = 1'b1;
    @(negedge clk_sys);
    fire_measure = 1'b0;
  endtask

  // Returns just after a rising edge on which pluse_us was sampled high.
  task automatic tick_edge();
    int k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (!pluse_us && k < 16);
    @(posedge clk_sys);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_edge();
  endtask

  task automatic wait_trig(input int c, input logic v, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk_sys);
      if (trig[c] === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * BOUND; k++) begin
      @(negedge clk_sys);
      if (done_measure === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference rules: width below timeout -> width/00; reaching timeout -> all-ones/10;
  // no rise -> 01 with old result kept.
  task automatic run_channel(input int c, input int kind, input int w);
    int t0;
    bit ok;
    t0 = trig_ticks[c];
    wait_trig(c, 1'b1, ok);
    chk($sformatf("trig%0d_rise", c), 32'(ok), 32'd1);
    wait_trig(c, 1'b0, ok);
    chk($sformatf("trig%0d_fall", c), 32'(ok), 32'd1);
    chk($sformatf("trig%0d_width", c), 32'(trig_ticks[c] - t0), 32'(TRIG_US));
    if (kind == K_NORISE) begin
      exp_err[c] = 1;
    end else begin
      ticks($urandom_range(8, 1));
      echo[c] = 1'b1;
      ticks(w);
      echo[c] = 1'b0;
      if (w >= TMO_US) begin
        exp_res[c] = (1 << CW) - 1;
        exp_err[c] = 2;
      end else begin
        exp_res[c] = w;
        exp_err[c] = 0;
      end
    end
  endtask

  task automatic check_regs();
    logic [7:0] lo, hi, e;
    for (int c = 0; c < NCH; c++) begin
      bus_rd(DEV, 16'(16'h10 + 2 * c), lo);
      bus_rd(DEV, 16'(16'h11 + 2 * c), hi);
      bus_rd(DEV, 16'(16'h30 + c), e);
      chk($sformatf("result%0d", c), {16'h0, hi, lo}, 32'(exp_res[c]));
      chk($sformatf("err%0d", c), {24'h0, e}, 32'(exp_err[c]));
    end
  endtask

  initial begin
    logic [7:0] d;
    bit ok;
    int w0, w2, d0, r1, r3;
    rst_n = 1'b0; fire_measure = 1'b0; echo = '0;
    fx_waddr = '0; fx_wr = 1'b0; fx_data = '0; fx_raddr = '0; fx_rd = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      exp_res[c] = 0;
      exp_err[c] = 0;
    end
    repeat (4) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);

    // Reset state
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_measure), 32'd0);
    chk("rst_fxq", 32'(fx_q), 32'd0);
    bus_rd(DEV, 16'h0001, d);
    chk("rst_chen", 32'(d), 32'h0F);
    bus_rd(DEV, 16'h0002, d);
    chk("rst_status", 32'(d), 32'h00);
    check_regs();

    // Sweep over ch0/ch2 only
    w0 = $urandom_range(150, 20);
    w2 = $urandom_range(150, 20);
    bus_wr(16'h0001, 8'h05);
    d0 = done_cnt;
    r1 = trig_rises[1];
    fire();
    chk("busy_after_fire", 32'(busy), 32'd1);
    run_channel(0, K_ECHO, w0);
    run_channel(2, K_ECHO, w2);
    wait_done(ok);
    chk("done_sweep1", 32'(ok), 32'd1);
    repeat (3) @(negedge clk_sys);
    chk("done_count1", 32'(done_cnt - d0), 32'd1);
    chk("busy_idle1", 32'(busy), 32'd0);
    chk("ch1_untouched", 32'(trig_rises[1] - r1), 32'd0);
    check_regs();

    // Sticky sweep_done cleared by read; foreign dev_id reads zero
    bus_rd(DEV, 16'h0002, d);
    chk("status_first", 32'(d), 32'h02);
    bus_rd(DEV, 16'h0002, d);
    chk("status_second", 32'(d), 32'h00);
    bus_rd(6'h15, 16'h0001, d);
    chk("wrong_dev", 32'(d), 32'h00);

    // No rise on ch1, overlong echo on ch2, ch3 already high; start via CTRL
    bus_wr(16'h0001, 8'h0F);
    echo[3] = 1'b1;
    r3 = trig_rises[3];
    d0 = done_cnt;
    bus_wr(16'h0000, 8'h01);
    run_channel(0, K_ECHO, $urandom_range(150, 20));
    run_channel(1, K_NORISE, 0);
    run_channel(2, K_ECHO, TMO_US + 30);
    exp_err[3] = 3;
    wait_done(ok);
    chk("done_sweep2", 32'(ok), 32'd1);
    echo[3] = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("done_count2", 32'(done_cnt - d0), 32'd1);
    chk("trig3_silent", 32'(trig_rises[3] - r3), 32'd0);
    check_regs();

    // Start with empty mask is ignored
    bus_wr(16'h0001, 8'h00);
    fire();
    chk("mask0_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk_sys);
    chk("mask0_idle", 32'(busy), 32'd0);

    // Continuous mode, then abort during the second sweep's measurement
    bus_wr(16'h0001, 8'h01);
    d0 = done_cnt;
    bus_wr(16'h0000, 8'h03);
    run_channel(0, K_ECHO, $urandom_range(150, 20));
    wait_done(ok);
    chk("done_cont", 32'(ok), 32'd1);
    bus_rd(DEV, 16'h0000, d);
    chk("ctrl_cont", 32'(d), 32'h02);
    wait_trig(0, 1'b1, ok);
    chk("cont_restart", 32'(ok), 32'd1);
    wait_trig(0, 1'b0, ok);
    ticks(3);
    echo[0] = 1'b1;
    ticks(6);
    bus_wr(16'h0000, 8'h04);
    chk("abort_trig", 32'(trig), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    ticks(4);
    echo[0] = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("abort_busy_hold", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd1);
    bus_rd(DEV, 16'h0000, d);
    chk("ctrl_after_abort", 32'(d), 32'h00);
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
